// File: rtl/piano_led_ctrl.sv
// Piano front-panel controller: synchronised note keys drive LEDs with afterglow,
// octave buttons step a saturating octave register. Optional macro PIANO_LED_SAT_FLASH_EN.
module piano_led_ctrl #(
    parameter int NUM_KEYS     = 7,
    parameter int OCT_BITS     = 3,
    parameter int OCT_MIN      = 0,
    parameter int OCT_MAX      = 6,
    parameter int OCT_RESET    = 3,
    parameter int HOLD_CYCLES  = 1000,
    parameter int FLASH_CYCLES = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    input  logic                up,
    input  logic                down,
    output logic [NUM_KEYS-1:0] led,
    output logic [OCT_BITS-1:0] octave,
    output logic                oct_evt
);

    localparam int TW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [TW-1:0]       HOLD_V      = TW'(HOLD_CYCLES);
    localparam logic [OCT_BITS-1:0] OCT_MIN_V   = OCT_BITS'(OCT_MIN);
    localparam logic [OCT_BITS-1:0] OCT_MAX_V   = OCT_BITS'(OCT_MAX);
    localparam logic [OCT_BITS-1:0] OCT_RESET_V = OCT_BITS'(OCT_RESET);

    if (OCT_MAX >= (1 << OCT_BITS) || OCT_RESET < OCT_MIN || OCT_RESET > OCT_MAX
        || OCT_MIN > OCT_MAX || HOLD_CYCLES < 0 || FLASH_CYCLES < 0) begin : g_bad_params
        $error("piano_led_ctrl: inconsistent parameters");
    end

    logic [NUM_KEYS-1:0] key_m, key_s;
    logic                up_m, up_s, up_s_d;
    logic                dn_m, dn_s, dn_s_d;
    logic                up_r, dn_r;
    logic [TW-1:0]       timer [NUM_KEYS];
    logic [NUM_KEYS-1:0] led_norm, led_next;
    logic [OCT_BITS-1:0] oct_next;
    logic                evt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_m  <= '0;
            key_s  <= '0;
            up_m   <= 1'b0;
            up_s   <= 1'b0;
            up_s_d <= 1'b0;
            dn_m   <= 1'b0;
            dn_s   <= 1'b0;
            dn_s_d <= 1'b0;
        end else begin
            key_m  <= key;
            key_s  <= key_m;
            up_m   <= up;
            up_s   <= up_m;
            up_s_d <= up_s;
            dn_m   <= down;
            dn_s   <= dn_m;
            dn_s_d <= dn_s;
        end
    end

    assign up_r = up_s & ~up_s_d;
    assign dn_r = dn_s & ~dn_s_d;

    // Timer reloads while the key is held, so a re-press never lets the LED drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) timer[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_s[i]) begin
                    timer[i] <= HOLD_V;
                end else if (timer[i] != '0) begin
                    timer[i] <= timer[i] - TW'(1);
                end
            end
        end
    end

    always_comb begin
        led_norm = key_s;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (timer[i] != '0) led_norm[i] = 1'b1;
        end
    end

    always_comb begin
        oct_next = octave;
        evt_next = 1'b0;
        if (up_r && !dn_r) begin
            if (octave < OCT_MAX_V) begin
                oct_next = octave + OCT_BITS'(1);
                evt_next = 1'b1;
            end else begin
                evt_next = oct_evt;
            end
        end else if (dn_r && !up_r) begin
            if (octave > OCT_MIN_V) begin
                oct_next = octave - OCT_BITS'(1);
                evt_next = 1'b1;
            end else begin
                evt_next = oct_evt;
            end
        end
    end

`ifdef PIANO_LED_SAT_FLASH_EN
    localparam int FW = (FLASH_CYCLES > 0) ? $clog2(FLASH_CYCLES + 1) : 1;
    logic [FW-1:0] flash_cnt;
    logic          reject;

    // Only a limit hit counts as a rejection; simultaneous up+down does not flash.
    assign reject = (up_r & ~dn_r & (octave == OCT_MAX_V))
                  | (dn_r & ~up_r & (octave == OCT_MIN_V));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt <= '0;
        end else if (reject) begin
            flash_cnt <= FW'(FLASH_CYCLES);
        end else if (flash_cnt != '0) begin
            flash_cnt <= flash_cnt - FW'(1);
        end
    end

    assign led_next = (flash_cnt != '0) ? '1 : led_norm;
`else
    assign led_next = led_norm;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led     <= '0;
            octave  <= OCT_RESET_V;
            oct_evt <= 1'b0;
        end else begin
            led     <= led_next;
            octave  <= oct_next;
            oct_evt <= evt_next;
        end
    end

endmodule

// File: tb/tb_piano_led_ctrl.sv
// Randomised and directed bench for piano_led_ctrl; two instances (HOLD=4 and HOLD=0)
// share stimulus and are compared each cycle against a history-based reference model.
module tb_piano_led_ctrl;

    localparam int HOLD_A = 4;
    localparam int HOLD_B = 0;
    localparam int FLASH  = 8;
    localparam int OMAX   = 6;
    localparam int OMIN   = 0;
    localparam int ORST   = 3;

    logic       clk;
    logic       rst_n;
    logic [6:0] key;
    logic       up;
    logic       down;
    logic [6:0] led_a, led_b;
    logic [2:0] oct_a, oct_b;
    logic       evt_a, evt_b;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: input histories (index 0 = value sampled at latest edge)
    logic [6:0] key_hist [8];
    logic       up_hist  [4];
    logic       dn_hist  [4];
    int         m_oct;
    logic       m_evt;
    int         m_flash;
    logic [6:0] exp_led_a, exp_led_b;

    piano_led_ctrl #(.NUM_KEYS(7), .OCT_BITS(3), .OCT_MIN(OMIN), .OCT_MAX(OMAX),
                     .OCT_RESET(ORST), .HOLD_CYCLES(HOLD_A), .FLASH_CYCLES(FLASH)) dut_a (
        .clk(clk), .rst_n(rst_n), .key(key), .up(up), .down(down),
        .led(led_a), .octave(oct_a), .oct_evt(evt_a));

    piano_led_ctrl #(.NUM_KEYS(7), .OCT_BITS(3), .OCT_MIN(OMIN), .OCT_MAX(OMAX),
                     .OCT_RESET(ORST), .HOLD_CYCLES(HOLD_B), .FLASH_CYCLES(FLASH)) dut_b (
        .clk(clk), .rst_n(rst_n), .key(key), .up(up), .down(down),
        .led(led_b), .octave(oct_b), .oct_evt(evt_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 8; i++) key_hist[i] = '0;
        for (int i = 0; i < 4; i++) begin
            up_hist[i] = 1'b0;
            dn_hist[i] = 1'b0;
        end
        m_oct   = ORST;
        m_evt   = 1'b0;
        m_flash = 0;
        exp_led_a = '0;
        exp_led_b = '0;
    endtask

    // LED is lit iff the key was seen pressed within the last hold+1 synchronised samples
    function automatic logic [6:0] ledFromHistory(input int hold);
        logic [6:0] acc = '0;
        for (int j = 2; j <= 2 + hold; j++) acc |= key_hist[j];
        return acc;
    endfunction

    task automatic checkOutput();
        check("led_hold4", {25'd0, led_a}, {25'd0, exp_led_a});
        check("led_hold0", {25'd0, led_b}, {25'd0, exp_led_b});
        check("octave_a", {29'd0, oct_a}, m_oct);
        check("octave_b", {29'd0, oct_b}, m_oct);
        check("oct_evt_a", {31'd0, evt_a}, {31'd0, m_evt});
        check("oct_evt_b", {31'd0, evt_b}, {31'd0, m_evt});
    endtask

    task automatic applyStimulus(input logic [6:0] k, input logic u, input logic d);
        logic ur, dr, rej, flash_on;
        @(negedge clk);
        key  = k;
        up   = u;
        down = d;
        @(posedge clk);
        for (int i = 7; i > 0; i--) key_hist[i] = key_hist[i-1];
        key_hist[0] = k;
        for (int i = 3; i > 0; i--) begin
            up_hist[i] = up_hist[i-1];
            dn_hist[i] = dn_hist[i-1];
        end
        up_hist[0] = u;
        dn_hist[0] = d;
        ur  = up_hist[2] & ~up_hist[3];
        dr  = dn_hist[2] & ~dn_hist[3];
        rej = 1'b0;
`ifdef PIANO_LED_SAT_FLASH_EN
        flash_on = (m_flash != 0);
`else
        flash_on = 1'b0;
`endif
        exp_led_a = flash_on ? 7'h7F : ledFromHistory(HOLD_A);
        exp_led_b = flash_on ? 7'h7F : ledFromHistory(HOLD_B);
        if (ur && !dr) begin
            if (m_oct < OMAX) begin
                m_oct++;
                m_evt = 1'b1;
            end else begin
                rej = 1'b1;
            end
        end else if (dr && !ur) begin
            if (m_oct > OMIN) begin
                m_oct--;
                m_evt = 1'b1;
            end else begin
                rej = 1'b1;
            end
        end else begin
            m_evt = 1'b0;
        end
        if (rej) m_flash = FLASH;
        else if (m_flash > 0) m_flash--;
        #1;
        checkOutput();
    endtask

    task automatic resetPulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        clearModel();
        check("rst_led_a", {25'd0, led_a}, 32'd0);
        check("rst_led_b", {25'd0, led_b}, 32'd0);
        check("rst_octave", {29'd0, oct_a}, ORST);
        check("rst_evt", {31'd0, evt_a}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(7'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        key   = '0;
        up    = 1'b0;
        down  = 1'b0;
        clearModel();
        $display("[TB] start");
        resetPulse();

        // Single key with afterglow
        for (int i = 0; i < 5; i++) applyStimulus(7'b0000100, 1'b0, 1'b0);
        idle(10);
        check("afterglow_done", {25'd0, led_a}, 32'd0);

        // Three up pulses then a saturating fourth
        for (int i = 0; i < 4; i++) begin
            applyStimulus(7'd0, 1'b1, 1'b0);
            idle(4);
        end
        check("oct_saturated", {29'd0, oct_a}, 32'd6);

        // Two downs, then up held for 20 clocks gives one step
        for (int i = 0; i < 2; i++) begin
            applyStimulus(7'd0, 1'b0, 1'b1);
            idle(4);
        end
        for (int i = 0; i < 20; i++) applyStimulus(7'd0, 1'b1, 1'b0);
        idle(4);
        check("held_up_once", {29'd0, oct_a}, 32'd5);

        // Simultaneous up and down
        applyStimulus(7'd0, 1'b1, 1'b1);
        idle(5);
        check("up_down_same", {29'd0, oct_a}, 32'd5);

        // Walk down to the floor and hit it once more
        for (int i = 0; i < 6; i++) begin
            applyStimulus(7'd0, 1'b0, 1'b1);
            idle(3);
        end
        applyStimulus(7'b0100000, 1'b0, 1'b0);
        idle(12);
        check("oct_floor", {29'd0, oct_a}, 32'd0);

        // All keys, then reset in the middle of the afterglow
        for (int i = 0; i < 4; i++) applyStimulus(7'h7F, 1'b0, 1'b0);
        idle(3);
        resetPulse();
        idle(8);
        check("no_residual_glow", {25'd0, led_a}, 32'd0);
        applyStimulus(7'h7F, 1'b0, 1'b0);
        idle(8);

        // Toggling key pattern exercises the zero-hold instance
        for (int i = 0; i < 12; i++) applyStimulus((i % 2 == 0) ? 7'h55 : 7'h2A, 1'b0, 1'b0);
        idle(8);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(7'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
